seg_scan_ctrl: RTL

Time-multiplexed scan scheduler for a common-anode multi-digit seven-segment display. It shares one segment bus between DIGITS digit positions in round-robin order.
- Scan rate comes from an internal prescaler on sysclk. It uses a single-cycle enable, not a derived clock.
- A blanking guard interval between digits suppresses ghosting.
- Display data is double-buffered and committed only at frame boundaries.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/hex_to_seg.sv | 15 +
 rtl/seg_scan_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller:
// active-low segment patterns and scan FSM state encoding.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern.
// Pure lookup into the shared pattern table.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // table lookup
    always_comb begin
        seg_o = SEG_HEX[nib_i];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan scheduler for a common-anode multi-digit display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int SCAN_HZ   = 1000,
    parameter int DIGITS    = 8,
    parameter int GUARD_CYC = 1000
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    output logic                  upd_pending,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int P  = CLK_HZ / SCAN_HZ;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int DW = 4 * DIGITS;

    localparam logic [PW-1:0] P_LAST = PW'(P - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYC - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]     presc_q;
    logic              tick;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [GW-1:0]     guard_q, guard_d;
    logic              commit;
    logic              fd_d;

    logic [DW-1:0]     act_data_q, act_data_d;
    logic [DIGITS-1:0] act_dp_q, act_dp_d;
    logic [DW-1:0]     pend_data_q, pend_data_d;
    logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic              upd_q, upd_d;

    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              fd_q;

    logic [3:0]        cur_nib;
    logic [6:0]        cur_seg;
    logic [DIGITS-1:0] lzb_vec;

    // free-running slot prescaler, tick on last count
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (presc_q == P_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick = (presc_q == P_LAST);

    // scan FSM state register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            guard_q <= guard_d;
        end
    end

    // scan FSM next state; commit at start-up and on each frame wrap
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        guard_d = guard_q;
        commit  = 1'b0;
        fd_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = BLANK;
                    idx_d   = '0;
                    guard_d = '0;
                    commit  = 1'b1;
                end
            end
            BLANK: begin
                if (guard_q == G_LAST) begin
                    state_d = SHOW;
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            SHOW: begin
                if (tick) begin
                    state_d = BLANK;
                    guard_d = '0;
                    if (idx_q == I_LAST) begin
                        idx_d  = '0;
                        fd_d   = 1'b1;
                        commit = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // double buffer; a load coinciding with a commit bypasses pending
    always_comb begin
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        upd_d       = upd_q;
        if (load && commit) begin
            act_data_d  = data_in;
            act_dp_d    = dp_in;
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            upd_d       = 1'b0;
        end else if (load) begin
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            upd_d       = 1'b1;
        end else if (commit && upd_q) begin
            act_data_d = pend_data_q;
            act_dp_d   = pend_dp_q;
            upd_d      = 1'b0;
        end
    end

    // buffer registers
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            act_data_q  <= '0;
            act_dp_q    <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            upd_q       <= 1'b0;
        end else begin
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            upd_q       <= upd_d;
        end
    end

    assign cur_nib = act_data_q[{idx_q, 2'b00} +: 4];

    hex_to_seg u_hex (
        .nib_i (cur_nib),
        .seg_o (cur_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;

    // a digit is blank when it and every higher digit are zero
    always_comb begin
        zero_run = 1'b1;
        lzb_vec  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run   = zero_run & (act_data_q[4*k +: 4] == 4'h0);
            lzb_vec[k] = zero_run & (k != 0);
        end
    end
`else
    assign lzb_vec = '0;
`endif

    // display drive decoded from the current state and index
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_q == SHOW) begin
            seg_d = cur_seg;
            dp_d  = ~act_dp_q[idx_q];
            if (digit_en[idx_q]) begin
                an_d[idx_q] = 1'b0;
            end
            if (lzb_vec[idx_q]) begin
                an_d  = '1;
                seg_d = SEG_BLANK;
                dp_d  = 1'b1;
            end
        end
    end

    // registered outputs, blank on reset
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            fd_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fd_q  <= fd_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_done  = fd_q;
    assign upd_pending = upd_q;

endmodule
